// File: rtl/cpu_pkg.sv
// Shared types and encodings for the cpu_controller slice.
// Optional interrupt entry is enabled by defining CTRL_IRQ_EN.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_HALT  = 3'd3,
    ST_IRQ   = 3'd4
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_NOR  = 4'b0011;
  localparam logic [3:0] OP_MOVR = 4'b0100;
  localparam logic [3:0] OP_STR  = 4'b0101;
  localparam logic [3:0] OP_JZR  = 4'b0110;
  localparam logic [3:0] OP_JZI  = 4'b0111;
  localparam logic [3:0] OP_JNR  = 4'b1000;
  localparam logic [3:0] OP_JNI  = 4'b1001;
  localparam logic [3:0] OP_SHL  = 4'b1011;
  localparam logic [3:0] OP_SHR  = 4'b1100;
  localparam logic [3:0] OP_LDI  = 4'b1101;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [1:0] SEL_ACC_ALU = 2'b00;
  localparam logic [1:0] SEL_ACC_REG = 2'b01;
  localparam logic [1:0] SEL_ACC_IMM = 2'b10;

  localparam logic [1:0] SEL_PC_REG = 2'b00;
  localparam logic [1:0] SEL_PC_IMM = 2'b01;
  localparam logic [1:0] SEL_PC_VEC = 2'b10;

  localparam logic [3:0] ALU_ADD = OP_ADD;
  localparam logic [3:0] ALU_SUB = OP_SUB;
  localparam logic [3:0] ALU_NOR = OP_NOR;
  localparam logic [3:0] ALU_SHL = OP_SHL;
  localparam logic [3:0] ALU_SHR = OP_SHR;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational EXEC decoder: opcode plus ALU flags to datapath controls.
// Unlisted opcodes fall through to the all-zero NOP bundle.
module ctrl_decode
  import cpu_pkg::*;
#(
  parameter int OPC_W   = 4,
  parameter int ALUOP_W = 4
) (
  input  logic [OPC_W-1:0]   opcode_i,
  input  logic               flagZ_i,
  input  logic               flagN_i,
  output logic               loadAcc_o,
  output logic [1:0]         selACC_o,
  output logic               loadReg_o,
  output logic               loadPC_o,
  output logic [1:0]         selPC_o,
  output logic [ALUOP_W-1:0] aluOp_o,
  output logic               halt_o
);

  always_comb begin
    loadAcc_o = 1'b0;
    selACC_o  = SEL_ACC_ALU;
    loadReg_o = 1'b0;
    loadPC_o  = 1'b0;
    selPC_o   = SEL_PC_REG;
    aluOp_o   = '0;
    halt_o    = 1'b0;
    case (opcode_i)
      OPC_W'(OP_ADD), OPC_W'(OP_SUB), OPC_W'(OP_NOR),
      OPC_W'(OP_SHL), OPC_W'(OP_SHR): begin
        aluOp_o   = ALUOP_W'(opcode_i);
        selACC_o  = SEL_ACC_ALU;
        loadAcc_o = 1'b1;
      end
      OPC_W'(OP_MOVR): begin
        selACC_o  = SEL_ACC_REG;
        loadAcc_o = 1'b1;
      end
      OPC_W'(OP_STR): loadReg_o = 1'b1;
      OPC_W'(OP_JZR): begin
        loadPC_o = flagZ_i;
        selPC_o  = flagZ_i ? SEL_PC_REG : 2'b00;
      end
      OPC_W'(OP_JZI): begin
        loadPC_o = flagZ_i;
        selPC_o  = flagZ_i ? SEL_PC_IMM : 2'b00;
      end
      OPC_W'(OP_JNR): begin
        loadPC_o = flagN_i;
        selPC_o  = flagN_i ? SEL_PC_REG : 2'b00;
      end
      OPC_W'(OP_JNI): begin
        loadPC_o = flagN_i;
        selPC_o  = flagN_i ? SEL_PC_IMM : 2'b00;
      end
      OPC_W'(OP_LDI): begin
        selACC_o  = SEL_ACC_IMM;
        loadAcc_o = 1'b1;
      end
      OPC_W'(OP_HALT): halt_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_controller.sv
// Fetch/execute/halt sequencer with imem wait-state handshake and retired counter.
// Define CTRL_IRQ_EN to build the one-cycle interrupt entry state.
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int INSTR_W = 8,
  parameter int OPC_W   = 4,
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic               imem_ack_i,
  input  logic               flagZ_i,
  input  logic               flagN_i,
  input  logic               resume_i,
  input  logic               irq_i,
  output logic               imem_req_o,
  output logic               loadIR_o,
  output logic               incPC_o,
  output logic               loadPC_o,
  output logic [1:0]         selPC_o,
  output logic               loadAcc_o,
  output logic [1:0]         selACC_o,
  output logic               loadReg_o,
  output logic               saveEpc_o,
  output logic               irq_ack_o,
  output logic [ALUOP_W-1:0] aluOp_o,
  output logic               halt_o,
  output logic [CNT_W-1:0]   instr_cnt_o
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   instrCnt_q, instrCnt_d;

  logic [OPC_W-1:0]   opcode;
  logic               decLoadAcc, decLoadReg, decLoadPC, decHalt;
  logic [1:0]         decSelACC, decSelPC;
  logic [ALUOP_W-1:0] decAluOp;
  logic [INSTR_W-OPC_W-1:0] unusedOperand;

  assign opcode        = instr_i[INSTR_W-1 -: OPC_W];
  assign unusedOperand = instr_i[INSTR_W-OPC_W-1:0];

`ifndef CTRL_IRQ_EN
  logic unusedIrq;
  assign unusedIrq = irq_i;
`endif

  ctrl_decode #(
    .OPC_W   (OPC_W),
    .ALUOP_W (ALUOP_W)
  ) u_decode (
    .opcode_i  (opcode),
    .flagZ_i   (flagZ_i),
    .flagN_i   (flagN_i),
    .loadAcc_o (decLoadAcc),
    .selACC_o  (decSelACC),
    .loadReg_o (decLoadReg),
    .loadPC_o  (decLoadPC),
    .selPC_o   (decSelPC),
    .aluOp_o   (decAluOp),
    .halt_o    (decHalt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      instrCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      instrCnt_q <= instrCnt_d;
    end
  end

  // Every EXEC cycle retires exactly one instruction, HALT and NOPs included.
  assign instrCnt_d  = (state_q == ST_EXEC) ? instrCnt_q + CNT_W'(1) : instrCnt_q;
  assign instr_cnt_o = instrCnt_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: if (imem_ack_i) state_d = ST_EXEC;
      ST_EXEC: begin
        if (decHalt) state_d = ST_HALT;
`ifdef CTRL_IRQ_EN
        else if (irq_i) state_d = ST_IRQ;
`endif
        else state_d = ST_FETCH;
      end
      ST_HALT:  if (resume_i) state_d = ST_FETCH;
`ifdef CTRL_IRQ_EN
      ST_IRQ:   state_d = ST_FETCH;
`endif
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    imem_req_o = 1'b0;
    loadIR_o   = 1'b0;
    incPC_o    = 1'b0;
    loadPC_o   = 1'b0;
    selPC_o    = SEL_PC_REG;
    loadAcc_o  = 1'b0;
    selACC_o   = SEL_ACC_ALU;
    loadReg_o  = 1'b0;
    saveEpc_o  = 1'b0;
    irq_ack_o  = 1'b0;
    aluOp_o    = '0;
    halt_o     = 1'b0;
    case (state_q)
      ST_FETCH: begin
        imem_req_o = 1'b1;
        loadIR_o   = imem_ack_i;
        incPC_o    = imem_ack_i;
      end
      ST_EXEC: begin
        loadPC_o  = decLoadPC;
        selPC_o   = decSelPC;
        loadAcc_o = decLoadAcc;
        selACC_o  = decSelACC;
        loadReg_o = decLoadReg;
        aluOp_o   = decAluOp;
        halt_o    = decHalt;
      end
      ST_HALT: halt_o = 1'b1;
`ifdef CTRL_IRQ_EN
      ST_IRQ: begin
        saveEpc_o = 1'b1;
        loadPC_o  = 1'b1;
        selPC_o   = SEL_PC_VEC;
        irq_ack_o = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller; counter built 4 bits wide to exercise wrap.
// Interrupt scenario follows CTRL_IRQ_EN as the RTL does.
module tb_cpu_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] instr;
  logic       imemAck, flagZ, flagN, resume, irq;
  logic       imemReq, loadIR, incPC, loadPC, loadAcc, loadReg, saveEpc, irqAck, halt;
  logic [1:0] selPC, selACC;
  logic [3:0] aluOp;
  logic [3:0] instrCnt;
  logic [16:0] allCtl;

  int checks   = 0;
  int failures = 0;

  assign allCtl = {imemReq, loadIR, incPC, loadPC, selPC, loadAcc, selACC,
                   loadReg, saveEpc, irqAck, aluOp, halt};

  always #5 clk = ~clk;

  cpu_controller #(
    .INSTR_W (8),
    .OPC_W   (4),
    .ALUOP_W (4),
    .CNT_W   (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_i     (instr),
    .imem_ack_i  (imemAck),
    .flagZ_i     (flagZ),
    .flagN_i     (flagN),
    .resume_i    (resume),
    .irq_i       (irq),
    .imem_req_o  (imemReq),
    .loadIR_o    (loadIR),
    .incPC_o     (incPC),
    .loadPC_o    (loadPC),
    .selPC_o     (selPC),
    .loadAcc_o   (loadAcc),
    .selACC_o    (selACC),
    .loadReg_o   (loadReg),
    .saveEpc_o   (saveEpc),
    .irq_ack_o   (irqAck),
    .aluOp_o     (aluOp),
    .halt_o      (halt),
    .instr_cnt_o (instrCnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the controller in IDLE, one cycle before its first fetch.
  task automatic doReset();
    rst = 1'b1; instr = 8'h00; imemAck = 1'b0; flagZ = 1'b0; flagN = 1'b0;
    resume = 1'b0; irq = 1'b0;
    #1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  // Called in FETCH; returns in the EXEC cycle of ins.
  task automatic fetchAndLoad(input logic [7:0] ins);
    imemAck = 1'b1;
    tick();
    imemAck = 1'b0;
    instr = ins;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; instr = 8'h00; imemAck = 1'b0; flagZ = 1'b0; flagN = 1'b0;
    resume = 1'b0; irq = 1'b0;
    #2;
    checks++;
    if (allCtl !== 17'h0) begin failures++; $display("[TB] FAIL reset_ctl: got %h want 0", allCtl); end
    checks++;
    if (instrCnt !== 4'd0) begin failures++; $display("[TB] FAIL reset_cnt: got %0d want 0", instrCnt); end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (allCtl !== 17'h0) begin failures++; $display("[TB] FAIL idle_ctl: got %h want 0", allCtl); end
    tick();
    checks++;
    if (imemReq !== 1'b1) begin failures++; $display("[TB] FAIL first_req: got %b want 1", imemReq); end
  endtask

  task automatic test_zero_wait();
    doReset();
    tick();
    imemAck = 1'b1;
    #1;
    checks++;
    if ({loadIR, incPC} !== 2'b11) begin failures++; $display("[TB] FAIL fetch_load: got %b want 11", {loadIR, incPC}); end
    tick(); imemAck = 1'b0; instr = 8'b1101_0011; #1;
    checks++;
    if ({loadAcc, selACC} !== 3'b110) begin failures++; $display("[TB] FAIL ldi_ctl: got %b want 110", {loadAcc, selACC}); end
    tick();
    checks++;
    if (instrCnt !== 4'd1) begin failures++; $display("[TB] FAIL cnt_after_1: got %0d want 1", instrCnt); end
    fetchAndLoad(8'b0101_0010);
    checks++;
    if ({loadReg, loadAcc} !== 2'b10) begin failures++; $display("[TB] FAIL str_ctl: got %b want 10", {loadReg, loadAcc}); end
    tick();
    fetchAndLoad(8'b1111_0000);
    checks++;
    if ({halt, imemReq} !== 2'b10) begin failures++; $display("[TB] FAIL halt_exec: got %b want 10", {halt, imemReq}); end
    tick();
    checks++;
    if (allCtl !== 17'h1) begin failures++; $display("[TB] FAIL halt_state: got %h want 00001", allCtl); end
    checks++;
    if (instrCnt !== 4'd3) begin failures++; $display("[TB] FAIL cnt_after_3: got %0d want 3", instrCnt); end
    imemAck = 1'b1;
    tick();
    #1;
    checks++;
    if (allCtl !== 17'h1) begin failures++; $display("[TB] FAIL halt_held: got %h want 00001", allCtl); end
    checks++;
    if (instrCnt !== 4'd3) begin failures++; $display("[TB] FAIL cnt_held: got %0d want 3", instrCnt); end
    imemAck = 1'b0;
  endtask

  task automatic test_resume();
    resume = 1'b1;
    tick();
    resume = 1'b0;
    #1;
    checks++;
    if ({imemReq, halt} !== 2'b10) begin failures++; $display("[TB] FAIL resume_fetch: got %b want 10", {imemReq, halt}); end
  endtask

  task automatic test_wait_states();
    int reqCnt = 0;
    int irCnt  = 0;
    doReset();
    tick();
    instr = 8'h00;
    resume = 1'b1;
    for (int i = 0; i < 4; i++) begin
      imemAck = (i == 3);
      #1;
      if (imemReq) reqCnt++;
      if (loadIR) irCnt++;
      tick();
    end
    resume = 1'b0;
    checks++;
    if (reqCnt !== 4) begin failures++; $display("[TB] FAIL wait_req_cycles: got %0d want 4", reqCnt); end
    checks++;
    if (irCnt !== 1) begin failures++; $display("[TB] FAIL wait_ir_pulses: got %0d want 1", irCnt); end
    imemAck = 1'b1;
    #1;
    checks++;
    if ({imemReq, loadIR} !== 2'b00) begin failures++; $display("[TB] FAIL ack_in_exec: got %b want 00", {imemReq, loadIR}); end
    imemAck = 1'b0;
    tick();
    checks++;
    if (instrCnt !== 4'd1) begin failures++; $display("[TB] FAIL wait_cnt: got %0d want 1", instrCnt); end
  endtask

  task automatic test_alu_branches();
    doReset();
    tick();
    fetchAndLoad(8'b0001_0101);
    checks++;
    if ({aluOp, loadAcc, selACC} !== 7'b0001_1_00) begin failures++; $display("[TB] FAIL add_ctl: got %b want 0001100", {aluOp, loadAcc, selACC}); end
    tick();
    fetchAndLoad(8'b1100_0000);
    checks++;
    if ({aluOp, loadAcc} !== 5'b1100_1) begin failures++; $display("[TB] FAIL shr_ctl: got %b want 11001", {aluOp, loadAcc}); end
    tick();
    fetchAndLoad(8'b0100_0001);
    checks++;
    if ({aluOp, loadAcc, selACC} !== 7'b0000_1_01) begin failures++; $display("[TB] FAIL movr_ctl: got %b want 0000101", {aluOp, loadAcc, selACC}); end
    tick();
    fetchAndLoad(8'b0111_0101);
    flagZ = 1'b1; #1;
    checks++;
    if ({loadPC, selPC} !== 3'b101) begin failures++; $display("[TB] FAIL jz_taken: got %b want 101", {loadPC, selPC}); end
    flagZ = 1'b0; flagN = 1'b1; #1;
    checks++;
    if (loadPC !== 1'b0) begin failures++; $display("[TB] FAIL jz_not_taken: got %b want 0", loadPC); end
    flagN = 1'b0;
    tick();
    fetchAndLoad(8'b1000_0010);
    flagN = 1'b1; #1;
    checks++;
    if ({loadPC, selPC} !== 3'b100) begin failures++; $display("[TB] FAIL jn_taken: got %b want 100", {loadPC, selPC}); end
    flagN = 1'b0;
    tick();
  endtask

  task automatic test_mid_fetch_reset();
    checks++;
    if (instrCnt !== 4'd5) begin failures++; $display("[TB] FAIL cnt_before_rst: got %0d want 5", instrCnt); end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (imemReq !== 1'b0) begin failures++; $display("[TB] FAIL rst_drops_req: got %b want 0", imemReq); end
    checks++;
    if (instrCnt !== 4'd0) begin failures++; $display("[TB] FAIL rst_clears_cnt: got %0d want 0", instrCnt); end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (allCtl !== 17'h0) begin failures++; $display("[TB] FAIL rst_idle: got %h want 0", allCtl); end
    tick();
    checks++;
    if (imemReq !== 1'b1) begin failures++; $display("[TB] FAIL rst_refetch: got %b want 1", imemReq); end
  endtask

  task automatic test_wrap_undefined();
    doReset();
    tick();
    for (int n = 0; n < 17; n++) begin
      fetchAndLoad(8'h00);
      tick();
    end
    checks++;
    if (instrCnt !== 4'd1) begin failures++; $display("[TB] FAIL cnt_wrap: got %0d want 1", instrCnt); end
    fetchAndLoad(8'b1010_0111);
    flagZ = 1'b1; flagN = 1'b1; #1;
    checks++;
    if (allCtl !== 17'h0) begin failures++; $display("[TB] FAIL undef_1010: got %h want 0", allCtl); end
    tick();
    fetchAndLoad(8'b1110_0000);
    checks++;
    if (allCtl !== 17'h0) begin failures++; $display("[TB] FAIL undef_1110: got %h want 0", allCtl); end
    flagZ = 1'b0; flagN = 1'b0;
    tick();
    checks++;
    if (instrCnt !== 4'd3) begin failures++; $display("[TB] FAIL cnt_undef: got %0d want 3", instrCnt); end
  endtask

  task automatic test_irq();
    doReset();
    tick();
    irq = 1'b1;
    tick();
    checks++;
    if ({imemReq, irqAck} !== 2'b10) begin failures++; $display("[TB] FAIL irq_in_fetch: got %b want 10", {imemReq, irqAck}); end
    fetchAndLoad(8'b0001_0011);
    checks++;
    if ({loadAcc, irqAck} !== 2'b10) begin failures++; $display("[TB] FAIL irq_add_exec: got %b want 10", {loadAcc, irqAck}); end
    tick();
`ifdef CTRL_IRQ_EN
    checks++;
    if ({saveEpc, irqAck, loadPC, selPC, imemReq} !== 6'b111100) begin
      failures++; $display("[TB] FAIL irq_entry: got %b want 111100", {saveEpc, irqAck, loadPC, selPC, imemReq});
    end
    tick();
    checks++;
    if ({imemReq, irqAck, saveEpc} !== 3'b100) begin failures++; $display("[TB] FAIL irq_return: got %b want 100", {imemReq, irqAck, saveEpc}); end
`else
    checks++;
    if ({imemReq, irqAck, saveEpc} !== 3'b100) begin failures++; $display("[TB] FAIL irq_ignored: got %b want 100", {imemReq, irqAck, saveEpc}); end
`endif
    checks++;
    if (instrCnt !== 4'd1) begin failures++; $display("[TB] FAIL irq_cnt: got %0d want 1", instrCnt); end
    fetchAndLoad(8'b1111_0000);
    tick();
    checks++;
    if ({halt, irqAck, imemReq} !== 3'b100) begin failures++; $display("[TB] FAIL halt_over_irq: got %b want 100", {halt, irqAck, imemReq}); end
    irq = 1'b0;
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_resume();
    test_wait_states();
    test_alu_branches();
    test_mid_fetch_reset();
    test_wrap_undefined();
    test_irq();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_controller.md
# cpu_controller

Parametrised successor to the 2-cycle processor controller FSM. It sequences fetch, execute and halt, and adds four things the earlier controller lacked:
- a wait-state handshake to instruction memory, so fetch can take any number of cycles;
- resume from HALT;
- a retired-instruction counter;
- an optional interrupt entry state.

It sits between the instruction register/PC/ALU datapath and instruction memory, and drives every datapath load and select.

## Interface
Parameters:
- INSTR_W, 8, instruction width; opcode is the top OPC_W bits, operand the remaining INSTR_W-OPC_W bits
- OPC_W, 4, opcode field width (minimum 4)
- ALUOP_W, 4, ALU opcode width; the opcode is zero-extended or truncated to this width
- CNT_W, 16, retired-instruction counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- instr  in  INSTR_W  instruction register contents
- imem_ack  in  1  instruction-memory data valid this cycle
- flagZ  in  1  ALU zero flag
- flagN  in  1  ALU negative flag
- resume  in  1  single-cycle pulse; leaves HALT
- irq  in  1  level interrupt request (used only with CTRL_IRQ_EN)
- imem_req  out  1  fetch request
- loadIR  out  1  IR <- memory data
- incPC  out  1  PC <- PC+1
- loadPC  out  1  PC <- source chosen by selPC
- selPC  out  2  00 = register, 01 = immediate, 10 = interrupt vector
- loadAcc  out  1  ACC <- source chosen by selACC
- selACC  out  2  00 = ALU, 01 = register, 10 = immediate
- loadReg  out  1  RF[operand] <- ACC
- saveEpc  out  1  EPC <- PC
- irq_ack  out  1  interrupt taken
- aluOp  out  ALUOP_W  ALU function
- halt  out  1  controller halted
- instr_cnt  out  CNT_W  retired instructions, registered

## Operation
- States: IDLE, FETCH, EXEC, HALT, IRQ. Only IRQ is reachable just with CTRL_IRQ_EN.
- Reset state is IDLE; instr_cnt = 0. All outputs are combinational from state, so every output is 0 while in IDLE.

State behaviour:
- **IDLE**: goes to FETCH unconditionally on the next edge.
- **FETCH**: imem_req = 1.
  - If imem_ack = 1: loadIR = 1 and incPC = 1 in that same cycle, and the next state is EXEC.
  - If imem_ack = 0: stay in FETCH with loadIR = incPC = 0.
- **EXEC**: decode the opcode; every control defaults to 0.
  - 0000 NOP.
  - 0001 ADD, 0010 SUB, 0011 NOR, 1011 SHL, 1100 SHR: aluOp = opcode, selACC = 00, loadAcc = 1.
  - 0100: selACC = 01, loadAcc = 1.
  - 0101: loadReg = 1.
  - 0110 / 0111: if flagZ, loadPC = 1 with selPC = 00 / 01.
  - 1000 / 1001: if flagN, loadPC = 1 with selPC = 00 / 01.
  - 1101: selACC = 10, loadAcc = 1.
  - 1111: halt = 1, and the next state is HALT.
  - Any other opcode (1010, 1110) executes as NOP.
- **EXEC exit**: instr_cnt increments by 1, wrapping at 2^CNT_W. This includes NOP, undefined opcodes and HALT. Next state is FETCH, or HALT for opcode 1111, or IRQ (see Configuration).
- **HALT**: halt = 1 and no other control asserted.
  - resume = 1 goes to FETCH.
  - instr_cnt is held.
- **IRQ**: saveEpc = 1, loadPC = 1, selPC = 10, irq_ack = 1 for exactly one cycle, then FETCH.

Boundary rules:
- imem_ack is ignored outside FETCH.
- resume is ignored outside HALT.
- rst asserted in any state, including mid-fetch, forces IDLE asynchronously, clears instr_cnt, and drops imem_req immediately.

## Timing
- With zero wait states each instruction takes 2 cycles (FETCH + EXEC); each cycle with imem_ack = 0 adds one cycle.
- A taken interrupt adds one cycle.
- After rst deasserts, the first imem_req is seen in the second cycle (the first is spent in IDLE).
- instr_cnt updates on the edge that ends EXEC, so it is visible in the following cycle.
- HALT is entered on the edge after the EXEC cycle of 1111.
- From HALT, resume sampled high at an edge makes FETCH active in the next cycle.

## Configuration
- Macro: CTRL_IRQ_EN.
- **Defined**:
  - irq is sampled in the EXEC cycle.
  - If irq = 1 and the opcode is not 1111, the next state is IRQ instead of FETCH.
  - HALT has priority over irq.
  - irq is not sampled during FETCH or HALT.
- **Undefined**:
  - IRQ state is not built.
  - irq is ignored.
  - saveEpc and irq_ack are tied to 0.
  - selPC never takes the value 10.

## Structure
- Shared package cpu_pkg holds:
  - the state enum;
  - opcode localparams (OP_NOP … OP_HALT);
  - selACC and selPC encodings;
  - ALU function codes.
- One sub-module, ctrl_decode: purely combinational, mapping opcode, flagZ and flagN to the EXEC control bundle. The top-level module holds the state register, the counter and the handshake logic.

## Test plan
- **Zero-wait sequence**: program 1101_0011, 0101_0010, 1111_0000 with imem_ack tied to 1 → EXEC cycles in order assert loadAcc/selACC = 10, then loadReg, then halt; halt is held; instr_cnt = 3; 6 cycles elapse before the HALT state.
- **Wait states**: imem_ack low for 3 cycles on the first fetch → imem_req stays high for 4 cycles, loadIR pulses exactly once, instr_cnt = 1 after EXEC.
- **Branches**: 0111_0101 with flagZ = 1 gives loadPC = 1, selPC = 01; with flagZ = 0 gives loadPC = 0. 1000_0010 with flagN = 1 gives loadPC = 1, selPC = 00.
- **Resume and reset**: resume pulse in HALT → FETCH next cycle. rst asserted mid-FETCH → imem_req = 0 immediately, instr_cnt = 0, IDLE then FETCH after release.
- **Wrap and undefined opcodes**: CNT_W = 4 with 17 NOPs → instr_cnt = 1. Opcode 1010 → all controls 0.
- **Interrupts** (CTRL_IRQ_EN defined): irq = 1 during EXEC of an ADD → one IRQ cycle with saveEpc = irq_ack = loadPC = 1, selPC = 10. irq = 1 during EXEC of 1111 → HALT and no irq_ack.
